// File: rtl/cpx_exec_unit.sv
// Sequencer/execute stage of the complex-number mini-CPU: fetch operands, add or
// multiply {re,im} pairs on a single shared multiplier, write back, repeat NUM_INSTR times.
module cpx_exec_unit #(
    parameter int ADDR_W    = 5,
    parameter int DW        = 8,
    parameter int NUM_INSTR = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] pc,
    input  logic              op,
    input  logic [ADDR_W-1:0] src0,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] dst,
    output logic [ADDR_W-1:0] dm_addr,
    input  logic [2*DW-1:0]   dm_rdata,
    output logic              dm_we,
    output logic [2*DW-1:0]   dm_wdata,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD_A, S_RD_B, S_ADD, S_MUL, S_WB, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(NUM_INSTR - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [2*DW-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2*DW:0]       acc_q, acc_d, acc_sum, prod_ext;
    logic [1:0]          k_q, k_d;
    logic signed [DW-1:0]   mul_x, mul_y;
    logic signed [2*DW-1:0] prod;

    // k selects the partial product: Ar*Br, Ai*Bi, Ar*Bi, Ai*Br
    always_comb begin
        mul_x = a_q[2*DW-1:DW];
        mul_y = b_q[2*DW-1:DW];
        case (k_q)
            2'd1:    begin mul_x = a_q[DW-1:0];    mul_y = b_q[DW-1:0];    end
            2'd2:    begin mul_x = a_q[2*DW-1:DW]; mul_y = b_q[DW-1:0];    end
            2'd3:    begin mul_x = a_q[DW-1:0];    mul_y = b_q[2*DW-1:DW]; end
            default: begin mul_x = a_q[2*DW-1:DW]; mul_y = b_q[2*DW-1:DW]; end
        endcase
        prod     = mul_x * mul_y;
        prod_ext = {prod[2*DW-1], prod};
        case (k_q)
            2'd1:    acc_sum = acc_q - prod_ext;
            2'd3:    acc_sum = acc_q + prod_ext;
            default: acc_sum = prod_ext;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        acc_d   = acc_q;
        k_d     = k_q;
        dm_addr = '0;
        dm_we   = 1'b0;
        done    = 1'b0;
        busy    = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: if (start) state_d = S_RD_A;
            S_RD_A: begin
                dm_addr = src0;
                a_d     = dm_rdata;
                state_d = S_RD_B;
            end
            S_RD_B: begin
                dm_addr = src1;
                b_d     = dm_rdata;
                k_d     = 2'd0;
                state_d = op ? S_MUL : S_ADD;
            end
            S_ADD: begin
                res_d   = {a_q[2*DW-1:DW] + b_q[2*DW-1:DW], a_q[DW-1:0] + b_q[DW-1:0]};
                state_d = S_WB;
            end
            S_MUL: begin
                acc_d = acc_sum;
                k_d   = k_q + 2'd1;
                // Real part is final after k1, imaginary after k3; keep only the low DW bits.
                if (k_q == 2'd1) res_d[2*DW-1:DW] = acc_sum[DW-1:0];
                if (k_q == 2'd3) begin
                    res_d[DW-1:0] = acc_sum[DW-1:0];
                    state_d       = S_WB;
                end
            end
            S_WB: begin
                dm_addr = dst;
                dm_we   = 1'b1;
                if (pc_q == LAST_PC) begin
                    state_d = S_DONE;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = S_RD_A;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                pc_d    = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            acc_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
        end
    end

    assign pc       = pc_q;
    assign dm_wdata = res_q;
endmodule

// File: tb/tb_cpx_exec_unit.sv
// Bench for cpx_exec_unit: directed and random programs checked against a sequential
// complex-arithmetic model of the program; a second instance covers a one-instruction program.
module tb_cpx_exec_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int chk = 0;
    int pass = 0;

    // main instance, 4-instruction program
    logic        start = 1'b0, op, dm_we, busy, done, load = 1'b0;
    logic [4:0]  pc, src0, src1, dst, dm_addr;
    logic [15:0] dm_rdata, dm_wdata;
    logic [15:0] mem [32];
    logic [15:0] init_mem [32];
    logic [15:0] mm [32];
    bit          p_op [32];
    logic [4:0]  p_s0 [32], p_s1 [32], p_dst [32];

    // single-instruction instance
    logic        start1 = 1'b0, op1, dm_we1, busy1, done1;
    logic [4:0]  pc1, src01, src11, dst1, dm_addr1;
    logic [15:0] dm_rdata1, dm_wdata1;
    logic [15:0] mem1 [32];

    assign op       = p_op[pc];
    assign src0     = p_s0[pc];
    assign src1     = p_s1[pc];
    assign dst      = p_dst[pc];
    assign dm_rdata = mem[dm_addr];
    assign op1      = 1'b0;
    assign src01    = 5'd1;
    assign src11    = 5'd2;
    assign dst1     = 5'd9;
    assign dm_rdata1 = mem1[dm_addr1];

    cpx_exec_unit #(.ADDR_W(5), .DW(8), .NUM_INSTR(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pc(pc), .op(op), .src0(src0), .src1(src1),
        .dst(dst), .dm_addr(dm_addr), .dm_rdata(dm_rdata), .dm_we(dm_we), .dm_wdata(dm_wdata),
        .busy(busy), .done(done));

    cpx_exec_unit #(.ADDR_W(5), .DW(8), .NUM_INSTR(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .pc(pc1), .op(op1), .src0(src01), .src1(src11),
        .dst(dst1), .dm_addr(dm_addr1), .dm_rdata(dm_rdata1), .dm_we(dm_we1), .dm_wdata(dm_wdata1),
        .busy(busy1), .done(done1));

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 32; i++) begin
                mem[i]  <= init_mem[i];
                mem1[i] <= init_mem[i];
            end
        end else begin
            if (dm_we)  mem[dm_addr]   <= dm_wdata;
            if (dm_we1) mem1[dm_addr1] <= dm_wdata1;
        end
    end

    int wb_pc [$];
    int done_tot = 0;
    always @(negedge clk) begin
        if (dm_we) wb_pc.push_back(int'(pc));
        if (done)  done_tot++;
    end

    function automatic logic [15:0] cexec(input bit o, input logic [15:0] a, input logic [15:0] b);
        int ar, ai, br, bi, re, im;
        ar = int'($signed(a[15:8])); ai = int'($signed(a[7:0]));
        br = int'($signed(b[15:8])); bi = int'($signed(b[7:0]));
        if (o) begin re = ar * br - ai * bi; im = ar * bi + ai * br; end
        else   begin re = ar + br;           im = ai + bi;           end
        return {re[7:0], im[7:0]};
    endfunction

    // Runs the program sequentially over a copy of init_mem; returns expected start-to-done cycles.
    function automatic int model_run();
        int cyc = 1;
        for (int i = 0; i < 32; i++) mm[i] = init_mem[i];
        for (int i = 0; i < 4; i++) begin
            mm[p_dst[i]] = cexec(p_op[i], mm[p_s0[i]], mm[p_s1[i]]);
            cyc += p_op[i] ? 7 : 4;
        end
        return cyc;
    endfunction

    task automatic set_instr(input int i, input bit o, input int d, input int s0, input int s1);
        p_op[i] = o; p_dst[i] = 5'(d); p_s0[i] = 5'(s0); p_s1[i] = 5'(s1);
    endtask

    task automatic load_mem();
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    // Pulses start, returns cycles from the start-sampling edge until done is seen.
    task automatic run_prog(input int mid_pc, output int cyc, output bit tmo);
        bit fired = 0;
        cyc = 0; tmo = 1;
        @(negedge clk); start = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (mid_pc >= 0 && !fired && busy && int'(pc) == mid_pc) begin
                start = 1'b1; fired = 1;
            end
            if (done) begin cyc = n; tmo = 0; break; end
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk++; if ({pc, busy, done, dm_we, dm_addr} !== 13'd0)
            $display("FAIL reset_outputs got pc=%0d busy=%b done=%b we=%b addr=%0d want all 0",
                     pc, busy, done, dm_we, dm_addr);
        else pass++;
        chk++; if ({pc1, busy1, done1, dm_we1} !== 8'd0)
            $display("FAIL reset_outputs1 got pc=%0d busy=%b done=%b want 0", pc1, busy1, done1);
        else pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int cyc, w0, exp_cyc; bit tmo;
        logic [15:0] want [4];
        want[0] = 16'hFB0A; want[1] = 16'h0204; want[2] = 16'hFC03; want[3] = 16'h0101;
        for (int i = 0; i < 32; i++) init_mem[i] = 16'h0;
        init_mem[0] = 16'h0102; init_mem[1] = 16'h0304; init_mem[2] = 16'h0001; init_mem[3] = 16'h0100;
        set_instr(0, 1, 4, 0, 1); set_instr(1, 0, 5, 0, 0);
        set_instr(2, 1, 6, 2, 1); set_instr(3, 0, 7, 2, 3);
        exp_cyc = model_run();
        load_mem();
        w0 = wb_pc.size();
        run_prog(-1, cyc, tmo);
        chk++; if (tmo || cyc !== 23) $display("FAIL directed_latency got %0d (timeout=%b) want 23", cyc, tmo);
        else pass++;
        chk++; if (exp_cyc !== 23) $display("FAIL model_latency got %0d want 23", exp_cyc); else pass++;
        chk++; if (wb_pc.size() - w0 !== 4) $display("FAIL directed_we_pulses got %0d want 4", wb_pc.size() - w0);
        else pass++;
        for (int i = 0; i < 4; i++) begin
            chk++; if (mem[4+i] !== want[i])
                $display("FAIL directed_mem%0d got %h want %h", 4 + i, mem[4+i], want[i]);
            else pass++;
        end
    endtask

    task automatic test_wrap();
        int cyc; bit tmo;
        for (int i = 0; i < 32; i++) init_mem[i] = 16'h0;
        init_mem[0] = 16'h7F00; init_mem[1] = 16'h0100; init_mem[3] = 16'h1000; init_mem[4] = 16'hFF00;
        set_instr(0, 0, 2, 0, 1); set_instr(1, 1, 5, 3, 3);
        set_instr(2, 1, 6, 4, 4); set_instr(3, 0, 7, 4, 4);
        load_mem();
        run_prog(-1, cyc, tmo);
        chk++; if (tmo || mem[2] !== 16'h8000) $display("FAIL add_overflow got %h want 8000", mem[2]); else pass++;
        chk++; if (mem[5] !== 16'h0000) $display("FAIL mul_wrap got %h want 0000", mem[5]); else pass++;
        chk++; if (mem[6] !== 16'h0100) $display("FAIL mul_neg got %h want 0100", mem[6]); else pass++;
        chk++; if (mem[7] !== 16'hFE00) $display("FAIL add_neg got %h want FE00", mem[7]); else pass++;
    endtask

    task automatic test_alias();
        int cyc; bit tmo;
        for (int i = 0; i < 32; i++) init_mem[i] = 16'h0;
        init_mem[0] = 16'h0102;
        set_instr(0, 0, 0, 0, 0); set_instr(1, 0, 1, 0, 0);
        set_instr(2, 1, 2, 1, 0); set_instr(3, 0, 3, 3, 3);
        void'(model_run());
        load_mem();
        run_prog(-1, cyc, tmo);
        chk++; if (tmo || mem[0] !== 16'h0204) $display("FAIL alias_mem0 got %h want 0204", mem[0]); else pass++;
        chk++; if (mem[1] !== 16'h0408) $display("FAIL alias_mem1 got %h want 0408", mem[1]); else pass++;
        chk++; if (mem[2] !== mm[2]) $display("FAIL alias_mem2 got %h want %h", mem[2], mm[2]); else pass++;
    endtask

    task automatic test_random();
        int cyc, exp_cyc, bad; bit tmo;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 32; i++) init_mem[i] = 16'($urandom);
            for (int i = 0; i < 4; i++)
                set_instr(i, 1'($urandom_range(0, 1)), $urandom_range(0, 31),
                          $urandom_range(0, 31), $urandom_range(0, 31));
            exp_cyc = model_run();
            load_mem();
            run_prog(-1, cyc, tmo);
            chk++; if (tmo || cyc !== exp_cyc)
                $display("FAIL rand%0d_latency got %0d (timeout=%b) want %0d", it, cyc, tmo, exp_cyc);
            else pass++;
            bad = 0;
            for (int i = 0; i < 32; i++) if (mem[i] !== mm[i]) begin
                if (bad == 0) $display("FAIL rand%0d_mem%0d got %h want %h", it, i, mem[i], mm[i]);
                bad++;
            end
            chk++; if (bad == 0) pass++;
        end
    endtask

    task automatic test_start_mid();
        int cyc, w0, d0; bit tmo;
        for (int i = 0; i < 32; i++) init_mem[i] = 16'($urandom);
        set_instr(0, 0, 8, 1, 2); set_instr(1, 1, 9, 3, 4);
        set_instr(2, 1, 10, 8, 9); set_instr(3, 0, 11, 10, 5);
        void'(model_run());
        load_mem();
        w0 = wb_pc.size(); d0 = done_tot;
        run_prog(2, cyc, tmo);
        repeat (30) @(negedge clk);
        chk++; if (tmo || wb_pc.size() - w0 !== 4)
            $display("FAIL midstart_we_pulses got %0d (timeout=%b) want 4", wb_pc.size() - w0, tmo);
        else pass++;
        for (int i = 0; i < 4 && w0 + i < wb_pc.size(); i++) begin
            chk++; if (wb_pc[w0+i] !== i) $display("FAIL midstart_pc%0d got %0d want %0d", i, wb_pc[w0+i], i);
            else pass++;
        end
        chk++; if (done_tot - d0 !== 1) $display("FAIL midstart_done_pulses got %0d want 1", done_tot - d0);
        else pass++;
        chk++; if (busy !== 1'b0) $display("FAIL midstart_idle busy=%b want 0", busy); else pass++;
        chk++; if (mem[11] !== mm[11]) $display("FAIL midstart_result got %h want %h", mem[11], mm[11]);
        else pass++;
    endtask

    task automatic test_reset_mid();
        int cyc, w0, exp_cyc, bad; bit tmo;
        for (int i = 0; i < 32; i++) init_mem[i] = 16'($urandom);
        set_instr(0, 1, 4, 0, 1); set_instr(1, 0, 5, 4, 2);
        set_instr(2, 1, 6, 5, 4); set_instr(3, 1, 7, 6, 3);
        exp_cyc = model_run();
        load_mem();
        w0 = wb_pc.size();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk++; if ({busy, pc, dm_we} !== 7'd0)
            $display("FAIL resetmid_outputs got busy=%b pc=%0d we=%b want 0", busy, pc, dm_we);
        else pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk++; if (wb_pc.size() != w0) $display("FAIL resetmid_no_write got %0d writes want 0", wb_pc.size() - w0);
        else pass++;
        chk++; if (mem[4] !== init_mem[4]) $display("FAIL resetmid_mem4 got %h want %h", mem[4], init_mem[4]);
        else pass++;
        run_prog(-1, cyc, tmo);
        chk++; if (tmo || cyc !== exp_cyc) $display("FAIL resetmid_rerun_latency got %0d want %0d", cyc, exp_cyc);
        else pass++;
        bad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== mm[i]) begin
            if (bad == 0) $display("FAIL resetmid_rerun_mem%0d got %h want %h", i, mem[i], mm[i]);
            bad++;
        end
        chk++; if (bad == 0) pass++;
    endtask

    task automatic test_single();
        int busy_n = 0, d = 0;
        logic [15:0] want;
        for (int i = 0; i < 32; i++) init_mem[i] = 16'($urandom);
        want = cexec(0, init_mem[1], init_mem[2]);
        load_mem();
        @(negedge clk); start1 = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (busy1) busy_n++;
            if (done1) d++;
        end
        chk++; if (busy_n !== 5) $display("FAIL single_busy_cycles got %0d want 5", busy_n); else pass++;
        chk++; if (d !== 1) $display("FAIL single_done_pulses got %0d want 1", d); else pass++;
        chk++; if (pc1 !== 5'd0 || busy1 !== 1'b0)
            $display("FAIL single_idle got pc=%0d busy=%b want 0/0", pc1, busy1);
        else pass++;
        chk++; if (mem1[9] !== want) $display("FAIL single_result got %h want %h", mem1[9], want); else pass++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            init_mem[i] = 16'h0; set_instr(i, 0, 0, 0, 0);
        end
        test_reset();
        test_directed();
        test_wrap();
        test_alias();
        test_random();
        test_start_mid();
        test_reset_mid();
        test_single();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
